line_window_buffer: RTL
=======================

LINE_WINDOW_BUFFER -- requirements
Module: line_window_buffer

Interface
REQ-001 The block SHALL have parameter IMG_WIDTH, default 640, meaning pixels per line (minimum 3).
REQ-002 The block SHALL have parameter IMG_HEIGHT, default 480, meaning lines per frame (minimum 3).
REQ-003 The block SHALL have parameter PIX_W, default 8, meaning bits per grayscale pixel.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state rises on its posedge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous reset, active-high.
REQ-007 The block SHALL have port sof, input, 1 bit: start of frame, qualified by pix_valid, marking pixel (0,0).
REQ-008 The block SHALL have port pix_valid, input, 1 bit: pix_in is valid this cycle.
REQ-009 The block SHALL have port pix_in, input, PIX_W bits: raster-order pixel, unsigned.
REQ-010 The block SHALL have port pix_ready, output, 1 bit: block accepts a pixel this cycle.
REQ-011 The block SHALL have port windowBuffer, output, 9 x PIX_W bits: 3x3 window, index 0..8 row-major.
REQ-012 The block SHALL have port start_calculations, output, 1 bit: windowBuffer is valid for the gradient stages.
REQ-013 The block SHALL have port out_ready, input, 1 bit: downstream consumes the window.
REQ-014 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last window of a frame is consumed.

Function
REQ-015 A pixel SHALL be accepted only when pix_valid=1 and pix_ready=1.
REQ-016 pix_ready SHALL equal NOT(start_calculations AND NOT out_ready).
REQ-017 The block SHALL keep two line buffers of IMG_WIDTH entries holding rows r-2 and r-1, plus a 3x3 shift register that shifts one column on each accepted pixel.
REQ-018 Window layout SHALL be: indices 0-2 = row r-2, indices 3-5 = row r-1, indices 6-8 = row r (current row); within each row, the lowest index is the oldest column.
REQ-019 The block SHALL track col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1); col wraps to 0 and row increments at end of line.
REQ-020 The state machine SHALL have the states IDLE, FILL and RUN.
REQ-021 The block SHALL be in IDLE after reset and SHALL move to FILL on an accepted pixel with sof=1.
REQ-022 FILL SHALL cover rows 0-1, and the block SHALL move to RUN at row 2, col 0.
REQ-023 From RUN, the block SHALL return to IDLE after the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted.
REQ-024 In IDLE, pixels without sof SHALL be accepted and discarded.
REQ-025 A window SHALL be produced only for accepted pixels with row>=2 and col>=2; the window is centred at (row-1, col-1) and border windows are not produced.
REQ-026 The block SHALL produce exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
REQ-027 Latency SHALL be: start_calculations rises the cycle after the qualifying pixel is accepted.
REQ-028 windowBuffer and start_calculations SHALL be registered and held stable while out_ready=0.
REQ-029 A window SHALL be consumed when start_calculations=1 and out_ready=1.
REQ-030 When a window is consumed and a new qualifying pixel is accepted in the same cycle, start_calculations SHALL stay at 1 and windowBuffer SHALL update with no bubble.
REQ-031 frame_done SHALL pulse one cycle after consumption of the final window.
REQ-032 An accepted pixel with sof=1 in any state SHALL restart the frame: row=0, col=1, state FILL, a pending window dropped, start_calculations=0 next cycle, and no frame_done.
REQ-033 pix_valid=0 SHALL freeze all counters and buffers.

Reset
REQ-034 While rst=1, the block SHALL hold state=IDLE, row=0, col=0, start_calculations=0, frame_done=0, windowBuffer all zero and pix_ready=1.
REQ-035 Line-buffer contents SHALL need no reset; they are overwritten during FILL before use.
REQ-036 Reset asserted mid-frame SHALL abandon the frame, and the block SHALL wait for the next sof.

Structure
REQ-037 A shared package sobel_pkg SHALL hold PIX_W, the window array typedef (9 x PIX_W) and the state enum.
REQ-038 The block SHALL contain one sub-module, line_buffer: single-port, depth IMG_WIDTH, width PIX_W, read-before-write at the same address, instantiated twice with the output of the first cascaded into the second.

Verification
REQ-039 For a 4x4 frame with pix_in = 16*row+col and out_ready=1, the bench SHALL see 4 windows: the first is {0,1,2,16,17,18,32,33,34}, the last is {17,18,19,33,34,35,49,50,51}, and frame_done pulses once.
REQ-040 With out_ready held at 0 for 5 cycles during the first window of a 640x480 frame, the bench SHALL see pix_ready=0 for 5 cycles, windowBuffer unchanged and no pixel lost; the total window count is 638*478.
REQ-041 With sof reasserted at (2,3) of a 4x4 frame, the bench SHALL see the pending window dropped, the counters restarted and the next full frame yield exactly 4 windows.
REQ-042 With rst pulsed asynchronously mid-RUN, the bench SHALL see outputs zero immediately and the block ignore pixels until sof.
REQ-043 With pix_valid toggling randomly with 50% duty over a 5x3 frame, the bench SHALL see the window values identical to the gapless run (3 windows).
REQ-044 With all-255 input on a 3x3 frame, the bench SHALL see exactly one window of nine 255s, with no overflow in the vertical gradient (gy=0).

Source files
------------

// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared pixel width, window type and state encoding
package sobel_pkg;

  localparam int PIX_W = 8;
  localparam int WIN_N = 9;

  typedef logic [WIN_N-1:0][PIX_W-1:0] window_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/line_window_buffer_if.sv
// rtl/line_window_buffer_if.sv - pixel-in / window-out handshake bundle
interface line_window_buffer_if #(
  parameter int PIX_W = sobel_pkg::PIX_W
);

  logic                                      sof;
  logic                                      pix_valid;
  logic [PIX_W-1:0]                          pix_in;
  logic                                      pix_ready;
  logic [sobel_pkg::WIN_N-1:0][PIX_W-1:0]    windowBuffer;
  logic                                      start_calculations;
  logic                                      out_ready;
  logic                                      frame_done;

  modport master (
    output sof, pix_valid, pix_in, out_ready,
    input  pix_ready, windowBuffer, start_calculations, frame_done
  );

  modport slave (
    input  sof, pix_valid, pix_in, out_ready,
    output pix_ready, windowBuffer, start_calculations, frame_done
  );

endinterface

// File: rtl/line_window_buffer_line_buffer.sv
// rtl/line_window_buffer_line_buffer.sv - single-port line memory, read-before-write
module line_buffer #(
  parameter int  DEPTH = 640,
  parameter int  WIDTH = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents need no reset: every column is rewritten during the first two rows.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  // Asynchronous read, so the word seen in the write cycle is the previous line's.
  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/line_window_buffer.sv
// rtl/line_window_buffer.sv - raster stream to 3x3 window generator
module line_window_buffer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = sobel_pkg::PIX_W
) (
  input logic                  clk,
  input logic                  rst,
  line_window_buffer_if.slave  bus
);

  import sobel_pkg::*;

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  state_e                         state_q, state_d;
  logic [CW-1:0]                  col_q, col_d;
  logic [RW-1:0]                  row_q, row_d;
  logic [WIN_N-1:0][PIX_W-1:0]    sr_q, sr_d;
  logic [WIN_N-1:0][PIX_W-1:0]    win_q, win_d;
  logic                           sc_q, sc_d;
  logic                           last_q, last_d;
  logic                           fd_q, fd_d;

  logic                           accept, start, in_frame, proc, qualify, consume;
  logic [CW-1:0]                  pix_col;
  logic [PIX_W-1:0]               lb1_rd, lb2_rd;

  assign bus.pix_ready          = !(sc_q && !bus.out_ready);
  assign bus.windowBuffer       = win_q;
  assign bus.start_calculations = sc_q;
  assign bus.frame_done         = fd_q;

  assign accept   = bus.pix_valid && bus.pix_ready;
  assign start    = accept && bus.sof;
  assign in_frame = accept && !bus.sof && (state_q != ST_IDLE);
  assign proc     = start || in_frame;
  assign pix_col  = start ? '0 : col_q;
  assign qualify  = in_frame && (row_q >= ROW_TWO) && (col_q >= COL_TWO);
  assign consume  = sc_q && bus.out_ready;

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb_r1 (
    .clk     (clk),
    .we_i    (proc),
    .addr_i  (pix_col),
    .wdata_i (bus.pix_in),
    .rdata_o (lb1_rd)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb_r2 (
    .clk     (clk),
    .we_i    (proc),
    .addr_i  (pix_col),
    .wdata_i (lb1_rd),
    .rdata_o (lb2_rd)
  );

  // Column shift of the 3x3 register; slot 2/5/8 of each row takes the newest column.
  always_comb begin
    sr_d = sr_q;
    if (proc) begin
      sr_d[0] = sr_q[1];
      sr_d[1] = sr_q[2];
      sr_d[2] = lb2_rd;
      sr_d[3] = sr_q[4];
      sr_d[4] = sr_q[5];
      sr_d[5] = lb1_rd;
      sr_d[6] = sr_q[7];
      sr_d[7] = sr_q[8];
      sr_d[8] = bus.pix_in;
    end
  end

  // Raster position and frame phase; sof restarts at column 1 since (0,0) is consumed now.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    if (start) begin
      state_d = ST_FILL;
      row_d   = '0;
      col_d   = CW'(1);
    end else if (in_frame) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d   = '0;
          state_d = ST_IDLE;
        end else begin
          row_d = row_q + 1'b1;
          if (row_q == ROW_ONE) state_d = ST_RUN;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Output window handshake; a restart drops whatever window is pending.
  always_comb begin
    win_d  = qualify ? sr_d : win_q;
    sc_d   = sc_q;
    last_d = last_q;
    if (start) begin
      sc_d   = 1'b0;
      last_d = 1'b0;
    end else if (qualify) begin
      sc_d   = 1'b1;
      last_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
    end else if (consume) begin
      sc_d   = 1'b0;
      last_d = 1'b0;
    end
    fd_d = consume && last_q;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      sr_q    <= '0;
      win_q   <= '0;
      sc_q    <= 1'b0;
      last_q  <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      sr_q    <= sr_d;
      win_q   <= win_d;
      sc_q    <= sc_d;
      last_q  <= last_d;
      fd_q    <= fd_d;
    end
  end

endmodule
